// File: rtl/fhe_fifo_pkg.sv
// fhe_fifo_pkg: shared FSM state type and default widths for the polynomial FIFOs
package fhe_fifo_pkg;
  typedef enum logic {IDLE, ACTIVE} fifo_state_e;
  localparam int DEF_BIT_WIDTH     = 64;
  localparam int DEF_LINE_SIZE     = 4;
  localparam int DEF_ADDR_WIDTH    = 9;
  localparam int DEF_POINTER_WIDTH = 1;
  localparam int DEF_RD_LATENCY    = 1;
endpackage

// File: rtl/poly_ram_bank.sv
// poly_ram_bank: true dual-port RAM bank with per-word write enables and a RD_LATENCY-deep read pipeline
module poly_ram_bank
  import fhe_fifo_pkg::*;
#(
  parameter int BIT_WIDTH  = DEF_BIT_WIDTH,
  parameter int LINE_SIZE  = DEF_LINE_SIZE,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int RD_LATENCY = DEF_RD_LATENCY
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          en,
  input  logic [LINE_SIZE-1:0]          we_a,
  input  logic [LINE_SIZE-1:0]          we_b,
  input  logic [ADDR_WIDTH-1:0]         addr_a,
  input  logic [ADDR_WIDTH-1:0]         addr_b,
  input  logic [BIT_WIDTH*LINE_SIZE-1:0] d_a,
  input  logic [BIT_WIDTH*LINE_SIZE-1:0] d_b,
  output logic [BIT_WIDTH*LINE_SIZE-1:0] q_a,
  output logic [BIT_WIDTH*LINE_SIZE-1:0] q_b
);
  logic [BIT_WIDTH*LINE_SIZE-1:0] mem [2**ADDR_WIDTH];
  logic [BIT_WIDTH*LINE_SIZE-1:0] pa [RD_LATENCY];
  logic [BIT_WIDTH*LINE_SIZE-1:0] pb [RD_LATENCY];
  // word-granular writes; port B is applied after port A so it wins a same-word collision
  always_ff @(posedge clk) begin
    for (int j = 0; j < LINE_SIZE; j++) begin
      if (we_a[j]) mem[addr_a][j*BIT_WIDTH +: BIT_WIDTH] <= d_a[j*BIT_WIDTH +: BIT_WIDTH];
      if (we_b[j]) mem[addr_b][j*BIT_WIDTH +: BIT_WIDTH] <= d_b[j*BIT_WIDTH +: BIT_WIDTH];
    end
  end
  // read-before-write capture on enable, then a free-running delay line up to RD_LATENCY
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int k = 0; k < RD_LATENCY; k++) begin
        pa[k] <= '0;
        pb[k] <= '0;
      end
    end else begin
      if (en) begin
        pa[0] <= mem[addr_a];
        pb[0] <= mem[addr_b];
      end
      for (int k = 1; k < RD_LATENCY; k++) begin
        pa[k] <= pa[k-1];
        pb[k] <= pb[k-1];
      end
    end
  end
  assign q_a = pa[RD_LATENCY-1];
  assign q_b = pb[RD_LATENCY-1];
endmodule

// File: rtl/poly_fifo_mbuf.sv
// poly_fifo_mbuf: multi-bank polynomial FIFO with commit/release handshakes, in-place loop port and sticky error flags
module poly_fifo_mbuf
  import fhe_fifo_pkg::*;
#(
  parameter int BIT_WIDTH     = DEF_BIT_WIDTH,
  parameter int LINE_SIZE     = DEF_LINE_SIZE,
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int POINTER_WIDTH = DEF_POINTER_WIDTH,
  parameter int FIFO_DEPTH    = 2**POINTER_WIDTH,
  parameter int RD_LATENCY    = DEF_RD_LATENCY
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           flush,
  input  logic                           src_finish,
  input  logic [ADDR_WIDTH-1:0]          src_addrA,
  input  logic [ADDR_WIDTH-1:0]          src_addrB,
  input  logic [BIT_WIDTH*LINE_SIZE-1:0] src_dA,
  input  logic [BIT_WIDTH*LINE_SIZE-1:0] src_dB,
  input  logic [LINE_SIZE-1:0]           src_selA,
  input  logic [LINE_SIZE-1:0]           src_selB,
  output logic                           src_full,
  input  logic                           loop_rd_en,
  output logic [BIT_WIDTH*LINE_SIZE-1:0] loop_doutA,
  output logic [BIT_WIDTH*LINE_SIZE-1:0] loop_doutB,
  input  logic                           snk_finish,
  input  logic [ADDR_WIDTH-1:0]          snk_addrA,
  input  logic [ADDR_WIDTH-1:0]          snk_addrB,
  input  logic                           snk_rd_en,
  output logic [BIT_WIDTH*LINE_SIZE-1:0] snk_dA,
  output logic [BIT_WIDTH*LINE_SIZE-1:0] snk_dB,
  output logic                           snk_valid,
  output logic                           snk_empty,
  output logic [POINTER_WIDTH:0]         count,
  output logic                           err_overflow,
  output logic                           err_underflow
);
  localparam int W  = BIT_WIDTH*LINE_SIZE;
  localparam int PW = POINTER_WIDTH;
  fifo_state_e wr_state, wr_next, rd_state, rd_next;
  logic [PW:0] wr_ptr, rd_ptr;
  logic [PW-1:0] wr_bank, rd_bank;
  logic clr, wr_allow, rd_issue, wr_commit, rd_release, ovf_set, unf_set;
  logic [PW-1:0] rd_idx [RD_LATENCY];
  logic [PW-1:0] lp_idx [RD_LATENCY];
  logic vld [RD_LATENCY];
  logic [W-1:0] qa [FIFO_DEPTH];
  logic [W-1:0] qb [FIFO_DEPTH];
  assign clr       = !rstn || flush;
  assign wr_bank   = wr_ptr[PW-1:0];
  assign rd_bank   = rd_ptr[PW-1:0];
  assign src_full  = (wr_bank == rd_bank) && (wr_ptr[PW] != rd_ptr[PW]);
  assign snk_empty = wr_ptr == rd_ptr;
  assign count     = wr_ptr - rd_ptr;
  assign wr_allow  = (wr_state == ACTIVE || !src_finish) && !src_full;
  assign rd_issue  = snk_rd_en && !snk_empty;
  // both handshake FSMs: start on finish low when a bank is available, commit/release on finish high
  always_comb begin
    wr_commit  = wr_state == ACTIVE && src_finish;
    rd_release = rd_state == ACTIVE && snk_finish;
    ovf_set    = wr_state == IDLE && !src_finish && src_full;
    unf_set    = rd_state == IDLE && !snk_finish && snk_empty;
    wr_next    = wr_commit ? IDLE : (wr_state == IDLE && !src_finish && !src_full) ? ACTIVE : wr_state;
    rd_next    = rd_release ? IDLE : (rd_state == IDLE && !snk_finish && !snk_empty) ? ACTIVE : rd_state;
  end
  // state, pointers and sticky errors; flush clears everything here just like reset
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_state      <= IDLE;
      rd_state      <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      wr_state      <= wr_next;
      rd_state      <= rd_next;
      wr_ptr        <= wr_ptr + (PW+1)'(wr_commit);
      rd_ptr        <= rd_ptr + (PW+1)'(rd_release);
      err_overflow  <= err_overflow | ovf_set;
      err_underflow <= err_underflow | unf_set;
    end
  end
  // issue-time bank indices and the sink strobe ride alongside the RAM read latency
  always_ff @(posedge clk) begin
    rd_idx[0] <= rd_bank;
    lp_idx[0] <= wr_bank;
    for (int k = 1; k < RD_LATENCY; k++) begin
      rd_idx[k] <= rd_idx[k-1];
      lp_idx[k] <= lp_idx[k-1];
    end
    if (clr) begin
      for (int k = 0; k < RD_LATENCY; k++) vld[k] <= 1'b0;
    end else begin
      vld[0] <= rd_issue;
      for (int k = 1; k < RD_LATENCY; k++) vld[k] <= vld[k-1];
    end
  end
  assign snk_valid  = vld[RD_LATENCY-1];
  assign snk_dA     = qa[rd_idx[RD_LATENCY-1]];
  assign snk_dB     = qb[rd_idx[RD_LATENCY-1]];
  assign loop_doutA = qa[lp_idx[RD_LATENCY-1]];
  assign loop_doutB = qb[lp_idx[RD_LATENCY-1]];
  for (genvar i = 0; i < FIFO_DEPTH; i++) begin : g_bank
    logic wr_hit, rd_hit, own_w, own_r, en;
    logic [LINE_SIZE-1:0] we_a, we_b;
    logic [ADDR_WIDTH-1:0] addr_a, addr_b;
    assign wr_hit = wr_bank == PW'(i);
    assign rd_hit = rd_bank == PW'(i);
    assign own_w  = wr_hit && !src_full;
    assign own_r  = rd_hit && !snk_empty;
    assign addr_a = own_w ? src_addrA : own_r ? snk_addrA : '0;
    assign addr_b = own_w ? src_addrB : own_r ? snk_addrB : '0;
    assign we_a   = (wr_hit && wr_allow) ? src_selA : '0;
    assign we_b   = (wr_hit && wr_allow) ? src_selB : '0;
    assign en     = (rd_hit && rd_issue) || (wr_hit && loop_rd_en);
    poly_ram_bank #(
      .BIT_WIDTH (BIT_WIDTH),
      .LINE_SIZE (LINE_SIZE),
      .ADDR_WIDTH(ADDR_WIDTH),
      .RD_LATENCY(RD_LATENCY)
    ) u_bank (
      .clk   (clk),
      .rstn  (rstn),
      .en    (en),
      .we_a  (we_a),
      .we_b  (we_b),
      .addr_a(addr_a),
      .addr_b(addr_b),
      .d_a   (src_dA),
      .d_b   (src_dB),
      .q_a   (qa[i]),
      .q_b   (qb[i])
    );
  end
endmodule

// File: tb/tb_poly_fifo_mbuf.sv
// tb_poly_fifo_mbuf: randomized scenario bench against a bank-level behavioural model
module tb_poly_fifo_mbuf;
  localparam int BW = 8, LS = 4, AW = 4, PW = 2, DEPTH = 4, L = 2;
  localparam int W = BW*LS, LINES = 2**AW;
  logic clk, rstn, flush, src_finish, loop_rd_en, snk_finish, snk_rd_en;
  logic [AW-1:0] src_addrA, src_addrB, snk_addrA, snk_addrB;
  logic [W-1:0] src_dA, src_dB, loop_doutA, loop_doutB, snk_dA, snk_dB;
  logic [LS-1:0] src_selA, src_selB;
  logic src_full, snk_valid, snk_empty, err_overflow, err_underflow;
  logic [PW:0] count;
  int checks = 0, errors = 0;
  int m_wr, m_rd;
  bit m_wact, m_ract, m_ovf, m_unf;
  logic [W-1:0] m_mem [DEPTH][LINES];
  bit pv [L];
  bit lv [L];
  logic [W-1:0] pa [L], pb [L], la [L], lb [L];

  poly_fifo_mbuf #(.BIT_WIDTH(BW), .LINE_SIZE(LS), .ADDR_WIDTH(AW), .POINTER_WIDTH(PW),
                   .FIFO_DEPTH(DEPTH), .RD_LATENCY(L)) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .src_finish(src_finish),
    .src_addrA(src_addrA), .src_addrB(src_addrB), .src_dA(src_dA), .src_dB(src_dB),
    .src_selA(src_selA), .src_selB(src_selB), .src_full(src_full),
    .loop_rd_en(loop_rd_en), .loop_doutA(loop_doutA), .loop_doutB(loop_doutB),
    .snk_finish(snk_finish), .snk_addrA(snk_addrA), .snk_addrB(snk_addrB),
    .snk_rd_en(snk_rd_en), .snk_dA(snk_dA), .snk_dB(snk_dB), .snk_valid(snk_valid),
    .snk_empty(snk_empty), .count(count), .err_overflow(err_overflow), .err_underflow(err_underflow));

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // advance one clock, updating the model from the inputs presented before the edge
  task automatic tick();
    int cnt = m_wr - m_rd;
    bit full = (cnt == DEPTH);
    bit empty = (cnt == 0);
    int wb = m_wr % DEPTH;
    int rb = m_rd % DEPTH;
    for (int k = L-1; k > 0; k--) begin
      pv[k] = pv[k-1]; pa[k] = pa[k-1]; pb[k] = pb[k-1];
      lv[k] = lv[k-1]; la[k] = la[k-1]; lb[k] = lb[k-1];
    end
    pv[0] = snk_rd_en && !empty;
    pa[0] = m_mem[rb][snk_addrA];
    pb[0] = m_mem[rb][snk_addrB];
    lv[0] = loop_rd_en;
    la[0] = m_mem[wb][src_addrA];
    lb[0] = m_mem[wb][src_addrB];
    if ((m_wact || !src_finish) && !full)
      for (int j = 0; j < LS; j++) begin
        if (src_selA[j]) m_mem[wb][src_addrA][j*BW +: BW] = src_dA[j*BW +: BW];
        if (src_selB[j]) m_mem[wb][src_addrB][j*BW +: BW] = src_dB[j*BW +: BW];
      end
    if (!rstn || flush) begin
      m_wr = 0; m_rd = 0; m_wact = 0; m_ract = 0; m_ovf = 0; m_unf = 0;
      for (int k = 0; k < L; k++) begin pv[k] = 0; lv[k] = 0; end
    end else begin
      if (m_wact && src_finish) begin m_wr++; m_wact = 0; end
      else if (!m_wact && !src_finish) begin if (full) m_ovf = 1; else m_wact = 1; end
      if (m_ract && snk_finish) begin m_rd++; m_ract = 0; end
      else if (!m_ract && !snk_finish) begin if (empty) m_unf = 1; else m_ract = 1; end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 0; src_finish = 1; snk_finish = 1; loop_rd_en = 0; snk_rd_en = 0;
    src_selA = '0; src_selB = '0; src_addrA = '0; src_addrB = '0; snk_addrA = '0; snk_addrB = '0;
    src_dA = '0; src_dB = '0;
  endtask

  task automatic fill_bank(input bit full_sel);
    src_finish = 0;
    for (int a = 0; a < LINES; a++) begin
      src_addrA = AW'(a);
      src_addrB = AW'($urandom_range(LINES-1));
      src_dA = $urandom; src_dB = $urandom;
      src_selA = full_sel ? '1 : LS'($urandom);
      src_selB = LS'($urandom);
      if (a == LINES-1) src_finish = 1;
      tick();
    end
    src_selA = '0; src_selB = '0;
  endtask

  task automatic drain_bank();
    int a = 0;
    snk_finish = 0;
    while (a < LINES) begin
      snk_rd_en = ($urandom_range(3) != 0);
      snk_addrA = AW'(a);
      snk_addrB = AW'($urandom_range(LINES-1));
      if (snk_rd_en && a == LINES-1) snk_finish = 1;
      if (snk_rd_en) a++;
      tick();
      checks++; if (snk_valid !== pv[L-1]) begin errors++; $display("FAIL drain_valid got %b want %b", snk_valid, pv[L-1]); end
      if (pv[L-1]) begin checks++; if ({snk_dA, snk_dB} !== {pa[L-1], pb[L-1]}) begin errors++; $display("FAIL drain_data got %h_%h want %h_%h", snk_dA, snk_dB, pa[L-1], pb[L-1]); end end
    end
    snk_rd_en = 0; snk_finish = 1;
    repeat (L+1) begin
      tick();
      checks++; if (snk_valid !== pv[L-1]) begin errors++; $display("FAIL drain_tail_valid got %b want %b", snk_valid, pv[L-1]); end
      if (pv[L-1]) begin checks++; if ({snk_dA, snk_dB} !== {pa[L-1], pb[L-1]}) begin errors++; $display("FAIL drain_tail_data got %h_%h want %h_%h", snk_dA, snk_dB, pa[L-1], pb[L-1]); end end
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rstn = 0;
    repeat (3) tick();
    rstn = 1;
    checks++; if (src_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", src_full); end
    checks++; if (snk_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", snk_empty); end
    checks++; if (count !== '0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (snk_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", snk_valid); end
    checks++; if ({err_overflow, err_underflow} !== 2'b00) begin errors++; $display("FAIL reset_err got %b want 00", {err_overflow, err_underflow}); end
    checks++; if ({snk_dA, loop_doutA} !== '0) begin errors++; $display("FAIL reset_data got %h_%h want 0", snk_dA, loop_doutA); end
  endtask

  task automatic test_underflow();
    snk_finish = 0; snk_rd_en = 1;
    tick();
    snk_finish = 1;
    repeat (L) tick();
    snk_rd_en = 0;
    checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL underflow_flag got %b want 1", err_underflow); end
    checks++; if (snk_valid !== 1'b0) begin errors++; $display("FAIL underflow_valid got %b want 0", snk_valid); end
    checks++; if (count !== '0 || snk_empty !== 1'b1) begin errors++; $display("FAIL underflow_ptr count %0d empty %b want 0 1", count, snk_empty); end
    flush = 1; tick(); flush = 0;
    checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL underflow_flush got %b want 0", err_underflow); end
  endtask

  task automatic test_overflow();
    repeat (DEPTH) fill_bank(1);
    checks++; if (src_full !== 1'b1) begin errors++; $display("FAIL ovf_full got %b want 1", src_full); end
    checks++; if (count !== (PW+1)'(DEPTH)) begin errors++; $display("FAIL ovf_count got %0d want %0d", count, DEPTH); end
    src_finish = 0; src_addrA = 3; src_dA = $urandom; src_selA = '1;
    tick();
    src_finish = 1; src_selA = '0;
    tick();
    checks++; if (err_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", err_overflow); end
    checks++; if (src_full !== 1'b1) begin errors++; $display("FAIL ovf_still_full got %b want 1", src_full); end
    repeat (DEPTH) drain_bank();
    checks++; if (count !== '0 || snk_empty !== 1'b1) begin errors++; $display("FAIL ovf_drained count %0d empty %b want 0 1", count, snk_empty); end
    checks++; if (err_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", err_overflow); end
    flush = 1; tick(); flush = 0;
    checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL ovf_flush got %b want 0", err_overflow); end
  endtask

  task automatic test_fill_drain();
    fill_bank(0);
    checks++; if (count !== 1 || snk_empty !== 1'b0) begin errors++; $display("FAIL commit count %0d empty %b want 1 0", count, snk_empty); end
    drain_bank();
    checks++; if (count !== 0 || snk_empty !== 1'b1) begin errors++; $display("FAIL release count %0d empty %b want 0 1", count, snk_empty); end
  endtask

  task automatic test_loop();
    logic [W-1:0] v1, v2, e2;
    v1 = $urandom; v2 = $urandom;
    src_finish = 0; src_addrA = 5; src_addrB = 5; src_dA = v1; src_selA = '1; src_selB = '0;
    tick();
    src_selA = '0; loop_rd_en = 1;
    tick();
    loop_rd_en = 0;
    repeat (L-1) tick();
    checks++; if (loop_doutA !== v1) begin errors++; $display("FAIL loop_full got %h want %h", loop_doutA, v1); end
    src_dA = v2; src_selA = 4'b0010;
    tick();
    src_selA = '0; loop_rd_en = 1;
    tick();
    loop_rd_en = 0;
    repeat (L-1) tick();
    e2 = v1;
    e2[15:8] = v2[15:8];
    checks++; if (loop_doutA !== e2) begin errors++; $display("FAIL loop_word1 got %h want %h", loop_doutA, e2); end
    checks++; if (loop_doutB !== lb[L-1]) begin errors++; $display("FAIL loop_portb got %h want %h", loop_doutB, lb[L-1]); end
    src_finish = 1;
    tick();
    drain_bank();
  endtask

  task automatic test_back_to_back();
    fill_bank(1);
    for (int it = 0; it < 10; it++) begin
      src_finish = 0; snk_finish = 0; snk_rd_en = 1;
      src_addrA = AW'($urandom); src_dA = $urandom; src_selA = '1;
      snk_addrA = AW'($urandom); snk_addrB = AW'($urandom);
      tick();
      checks++; if (snk_valid !== pv[L-1]) begin errors++; $display("FAIL b2b_valid got %b want %b", snk_valid, pv[L-1]); end
      src_finish = 1; snk_finish = 1; snk_rd_en = 0; src_selA = '0;
      tick();
      checks++; if (count !== 1 || src_full !== 1'b0 || snk_empty !== 1'b0) begin errors++; $display("FAIL b2b_count it %0d count %0d full %b empty %b want 1 0 0", it, count, src_full, snk_empty); end
      checks++; if (snk_valid !== 1'b1 || {snk_dA, snk_dB} !== {pa[L-1], pb[L-1]}) begin errors++; $display("FAIL b2b_data it %0d valid %b got %h_%h want %h_%h", it, snk_valid, snk_dA, snk_dB, pa[L-1], pb[L-1]); end
    end
    drain_bank();
  endtask

  task automatic test_flush_mid();
    src_finish = 0; src_selA = '1;
    for (int a = 0; a < 3; a++) begin src_addrA = AW'(a); src_dA = $urandom; tick(); end
    src_finish = 1; src_selA = '0; flush = 1;
    tick();
    flush = 0;
    checks++; if (count !== 0 || snk_empty !== 1'b1 || src_full !== 1'b0) begin errors++; $display("FAIL flush_mid count %0d empty %b full %b want 0 1 0", count, snk_empty, src_full); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      src_finish = $urandom_range(3) != 0 ? src_finish : ~src_finish;
      snk_finish = $urandom_range(3) != 0 ? snk_finish : ~snk_finish;
      snk_rd_en = $urandom_range(1);
      src_addrA = AW'($urandom); src_addrB = AW'($urandom);
      snk_addrA = AW'($urandom); snk_addrB = AW'($urandom);
      src_dA = $urandom; src_dB = $urandom;
      src_selA = LS'($urandom); src_selB = LS'($urandom);
      loop_rd_en = ($urandom_range(1) == 1) && (m_wr - m_rd != DEPTH);
      flush = ($urandom_range(63) == 0);
      tick();
      checks++; if (count !== (PW+1)'(m_wr - m_rd)) begin errors++; $display("FAIL rnd_count cyc %0d got %0d want %0d", c, count, m_wr - m_rd); end
      checks++; if ({src_full, snk_empty} !== {m_wr - m_rd == DEPTH, m_wr == m_rd}) begin errors++; $display("FAIL rnd_flags cyc %0d got %b%b want %b%b", c, src_full, snk_empty, m_wr - m_rd == DEPTH, m_wr == m_rd); end
      checks++; if ({err_overflow, err_underflow} !== {m_ovf, m_unf}) begin errors++; $display("FAIL rnd_err cyc %0d got %b%b want %b%b", c, err_overflow, err_underflow, m_ovf, m_unf); end
      checks++; if (snk_valid !== pv[L-1]) begin errors++; $display("FAIL rnd_valid cyc %0d got %b want %b", c, snk_valid, pv[L-1]); end
      if (pv[L-1]) begin checks++; if ({snk_dA, snk_dB} !== {pa[L-1], pb[L-1]}) begin errors++; $display("FAIL rnd_data cyc %0d got %h_%h want %h_%h", c, snk_dA, snk_dB, pa[L-1], pb[L-1]); end end
      if (lv[L-1]) begin checks++; if ({loop_doutA, loop_doutB} !== {la[L-1], lb[L-1]}) begin errors++; $display("FAIL rnd_loop cyc %0d got %h_%h want %h_%h", c, loop_doutA, loop_doutB, la[L-1], lb[L-1]); end end
    end
    idle_inputs();
  endtask

  initial begin
    m_wr = 0; m_rd = 0; m_wact = 0; m_ract = 0; m_ovf = 0; m_unf = 0;
    rstn = 0;
    idle_inputs();
    test_reset();
    test_underflow();
    test_overflow();
    test_fill_drain();
    test_loop();
    test_back_to_back();
    test_flush_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
